// File: rtl/battleship_pkg.sv
// Shared types and constants for the shot-scoring request path.
package battleship_pkg;

    // Shot-request sequencer states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT    = 3'd2,
        S_UPDATE  = 3'd3,
        S_RELEASE = 3'd4
    } shot_state_t;

    // One-hot encoding of the biggest ship hit by a shot
    localparam logic [4:0] SHIP_NONE  = 5'b00000;
    localparam logic [4:0] PATROL     = 5'b00001;
    localparam logic [4:0] SUB        = 5'b00010;
    localparam logic [4:0] CRUISER    = 5'b00100;
    localparam logic [4:0] BATTLESHIP = 5'b01000;
    localparam logic [4:0] CARRIER    = 5'b10000;

    localparam int COORD_W = 4;
    localparam int CNT_W   = 8;

    // Tally addition that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Synchronizes and debounces the active-low score key; emits a one-cycle
// pulse when the debounced level falls (a clean press).
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clock,
    input  logic reset_L,
    input  logic key_L,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] hold_cnt;

    // Two-flop synchronizer; idles high because the key is active-low
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= key_L;
            sync_p1 <= sync_p0;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES straight cycles
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            level    <= 1'b1;
            hold_cnt <= '0;
            press    <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_p1 == level) begin
                hold_cnt <= '0;
            end else if (hold_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level    <= sync_p1;
                hold_cnt <= '0;
                press    <= ~sync_p1;
            end else begin
                hold_cnt <= hold_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/shot_controller.sv
// Request side of the shot-scoring interface: turns a debounced key press
// into a single score request, waits for the scorer (or gives up), and keeps
// the result registers, big-bomb inventory and running tallies.
module shot_controller
    import battleship_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int BIG_BOMBS       = 2,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic               clock,
    input  logic               reset_L,
    input  logic               key_score_L,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    input  logic               big_in,
    output logic               score_req,
    output logic [COORD_W-1:0] score_x,
    output logic [COORD_W-1:0] score_y,
    output logic               score_big,
    output logic [1:0]         big_left,
    input  logic               rsp_valid,
    input  logic               rsp_wrong,
    input  logic               rsp_hit,
    input  logic               rsp_near,
    input  logic               rsp_miss,
    input  logic [4:0]         rsp_ship,
    input  logic [3:0]         rsp_num_hit,
    output logic               res_hit,
    output logic               res_near,
    output logic               res_miss,
    output logic [4:0]         res_ship,
    output logic [3:0]         res_num_hit,
    output logic               res_wrong,
    output logic               res_timeout,
    output logic               result_valid,
    output logic [CNT_W-1:0]   shots_fired,
    output logic [CNT_W-1:0]   hits_total
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    shot_state_t   state;
    logic [TW-1:0] tmo_cnt;
    logic          key_level;
    logic          key_press;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clock   (clock),
        .reset_L (reset_L),
        .key_L   (key_score_L),
        .level   (key_level),
        .press   (key_press)
    );

    // Shot sequencer. Results, tallies and inventory are loaded on the edge
    // that enters UPDATE, so result_valid is high for the UPDATE cycle itself
    // and the res_* values appear the cycle after rsp_valid is sampled.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state        <= S_IDLE;
            tmo_cnt      <= '0;
            score_req    <= 1'b0;
            score_x      <= '0;
            score_y      <= '0;
            score_big    <= 1'b0;
            big_left     <= 2'(BIG_BOMBS);
            res_hit      <= 1'b0;
            res_near     <= 1'b0;
            res_miss     <= 1'b0;
            res_ship     <= SHIP_NONE;
            res_num_hit  <= '0;
            res_wrong    <= 1'b0;
            res_timeout  <= 1'b0;
            result_valid <= 1'b0;
            shots_fired  <= '0;
            hits_total   <= '0;
        end else begin
            score_req    <= 1'b0;
            result_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (key_press) begin
                        score_x   <= x_in;
                        score_y   <= y_in;
                        score_big <= big_in;
                        score_req <= 1'b1;
                        state     <= S_REQ;
                    end
                end

                S_REQ: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT;
                end

                S_WAIT: begin
                    if (rsp_valid) begin
                        state        <= S_UPDATE;
                        result_valid <= 1'b1;
                        res_timeout  <= 1'b0;
                        if (rsp_wrong) begin
                            // Rejected shot: flag it, leave tallies and inventory alone
                            res_wrong   <= 1'b1;
                            res_hit     <= 1'b0;
                            res_near    <= 1'b0;
                            res_miss    <= 1'b0;
                            res_ship    <= SHIP_NONE;
                            res_num_hit <= '0;
                        end else begin
                            res_wrong   <= 1'b0;
                            res_hit     <= rsp_hit;
                            res_near    <= rsp_near;
                            res_miss    <= rsp_miss;
                            res_ship    <= rsp_ship;
                            res_num_hit <= rsp_num_hit;
                            shots_fired <= sat_add(shots_fired, CNT_W'(1));
                            hits_total  <= sat_add(hits_total, CNT_W'(rsp_num_hit));
                            if (score_big && (big_left != 2'd0))
                                big_left <= big_left - 2'd1;
                        end
                    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        // Last permitted WAIT cycle without a response: abandon the shot
                        state        <= S_UPDATE;
                        result_valid <= 1'b1;
                        res_timeout  <= 1'b1;
                        res_wrong    <= 1'b1;
                        res_hit      <= 1'b0;
                        res_near     <= 1'b0;
                        res_miss     <= 1'b0;
                        res_ship     <= SHIP_NONE;
                        res_num_hit  <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                S_UPDATE: begin
                    state <= S_RELEASE;
                end

                S_RELEASE: begin
                    // A held key must be let go before another shot can start
                    if (key_level)
                        state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shot_controller.sv
// Scoreboard bench for shot_controller: stimulus pushes expected requests and
// results; an independent monitor pops and compares on score_req/result_valid.
module tb_shot_controller;
    import battleship_pkg::*;

    localparam int DEB  = 4;
    localparam int TMO  = 16;
    localparam int BIGB = 2;

    logic       clock = 1'b0;
    logic       reset_L = 1'b0;
    logic       key_score_L = 1'b1;
    logic [3:0] x_in = '0;
    logic [3:0] y_in = '0;
    logic       big_in = 1'b0;
    logic       score_req;
    logic [3:0] score_x, score_y;
    logic       score_big;
    logic [1:0] big_left;
    logic       rsp_valid = 1'b0, rsp_wrong = 1'b0;
    logic       rsp_hit = 1'b0, rsp_near = 1'b0, rsp_miss = 1'b0;
    logic [4:0] rsp_ship = '0;
    logic [3:0] rsp_num_hit = '0;
    logic       res_hit, res_near, res_miss;
    logic [4:0] res_ship;
    logic [3:0] res_num_hit;
    logic       res_wrong, res_timeout, result_valid;
    logic [7:0] shots_fired, hits_total;

    shot_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .BIG_BOMBS      (BIGB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock(clock), .reset_L(reset_L), .key_score_L(key_score_L),
        .x_in(x_in), .y_in(y_in), .big_in(big_in),
        .score_req(score_req), .score_x(score_x), .score_y(score_y),
        .score_big(score_big), .big_left(big_left),
        .rsp_valid(rsp_valid), .rsp_wrong(rsp_wrong), .rsp_hit(rsp_hit),
        .rsp_near(rsp_near), .rsp_miss(rsp_miss), .rsp_ship(rsp_ship),
        .rsp_num_hit(rsp_num_hit),
        .res_hit(res_hit), .res_near(res_near), .res_miss(res_miss),
        .res_ship(res_ship), .res_num_hit(res_num_hit), .res_wrong(res_wrong),
        .res_timeout(res_timeout), .result_valid(result_valid),
        .shots_fired(shots_fired), .hits_total(hits_total)
    );

    initial forever #5 clock = ~clock;

    typedef struct {
        logic [3:0] x, y;
        logic       big;
    } req_t;

    typedef struct {
        logic       hit, near, miss;
        logic [4:0] ship;
        logic [3:0] num;
        logic       wrong, tmo;
        logic [1:0] bl;
        logic [7:0] sf, ht;
        logic [3:0] sx, sy;
    } res_t;

    req_t exp_req[$];
    res_t exp_res[$];

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    int req_cnt = 0, req_cyc = 0, rv_cnt = 0, rv_cyc = 0;

    // Reference model state: inventory and tallies as plain integers
    int m_big = BIGB, m_shots = 0, m_hits = 0;

    logic [4:0] ships [6];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Monitor: pops the scoreboard whenever the DUT presents a request or a result
    initial begin : monitor
        req_t er;
        res_t ee;
        forever begin
            @(negedge clock);
            if (score_req) begin
                req_cnt++;
                req_cyc = cyc;
                if (exp_req.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL req_unexpected: score_req with x=%0d y=%0d and nothing expected", score_x, score_y);
                end else begin
                    er = exp_req.pop_front();
                    chk("score_x", score_x, er.x);
                    chk("score_y", score_y, er.y);
                    chk("score_big", score_big, er.big);
                end
            end
            if (result_valid) begin
                rv_cnt++;
                rv_cyc = cyc;
                if (exp_res.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rv_unexpected: result_valid with nothing expected");
                end else begin
                    ee = exp_res.pop_front();
                    chk("res_hit", res_hit, ee.hit);
                    chk("res_near", res_near, ee.near);
                    chk("res_miss", res_miss, ee.miss);
                    chk("res_ship", res_ship, ee.ship);
                    chk("res_num_hit", res_num_hit, ee.num);
                    chk("res_wrong", res_wrong, ee.wrong);
                    chk("res_timeout", res_timeout, ee.tmo);
                    chk("big_left", big_left, ee.bl);
                    chk("shots_fired", shots_fired, ee.sf);
                    chk("hits_total", hits_total, ee.ht);
                    chk("score_x_held", score_x, ee.sx);
                    chk("score_y_held", score_y, ee.sy);
                end
            end
        end
    end

    task automatic wait_req(input int r0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (req_cnt != r0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rv(input int v0, output bit ok);
        ok = (rv_cnt != v0);
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (rv_cnt != v0) ok = 1'b1;
        end
    endtask

    // mode: 0 = accepted shot, 1 = scorer rejects, 2 = scorer never answers
    task automatic do_shot(input int mode, input logic [3:0] x, input logic [3:0] y,
                           input logic big, input int d,
                           input logic hit, input logic near, input logic miss,
                           input logic [4:0] ship, input logic [3:0] num,
                           input int hold, input bit late_rsp);
        int   r0, v0, k, exp_cyc;
        bit   ok;
        req_t rq;
        res_t e;
        x_in = x; y_in = y; big_in = big;
        rq.x = x; rq.y = y; rq.big = big;
        exp_req.push_back(rq);
        r0 = req_cnt; v0 = rv_cnt; k = cyc;
        key_score_L = 1'b0;
        wait_req(r0, ok);
        if (!ok) begin
            chk("req_seen", 0, 1);
            exp_req.delete();
            key_score_L = 1'b1;
            repeat (20) tick();
            return;
        end
        chk("press_latency", req_cyc - k, DEB + 3);
        // Inputs wander after the latch; the shot in flight must not notice
        x_in = 4'($urandom); y_in = 4'($urandom); big_in = 1'($urandom);

        e.sx = x; e.sy = y;
        if (mode == 0) begin
            e.hit = hit; e.near = near; e.miss = miss; e.ship = ship; e.num = num;
            e.wrong = 1'b0; e.tmo = 1'b0;
            m_shots = (m_shots + 1 > 255) ? 255 : m_shots + 1;
            m_hits  = (m_hits + int'(num) > 255) ? 255 : m_hits + int'(num);
            if (big && m_big > 0) m_big = m_big - 1;
        end else begin
            e.hit = 1'b0; e.near = 1'b0; e.miss = 1'b0; e.ship = SHIP_NONE; e.num = 4'd0;
            e.wrong = 1'b1; e.tmo = (mode == 2);
        end
        e.bl = 2'(m_big); e.sf = 8'(m_shots); e.ht = 8'(m_hits);
        exp_res.push_back(e);

        if (mode == 2) begin
            exp_cyc = req_cyc + 1 + TMO;
        end else begin
            tick();
            repeat (d) tick();
            rsp_valid = 1'b1; rsp_wrong = (mode == 1);
            rsp_hit = hit; rsp_near = near; rsp_miss = miss;
            rsp_ship = ship; rsp_num_hit = num;
            tick();
            rsp_valid = 1'b0; rsp_wrong = 1'b0;
            exp_cyc = req_cyc + 2 + d;
        end
        wait_rv(v0, ok);
        if (!ok) begin
            chk("rv_seen", 0, 1);
            exp_res.delete();
        end else begin
            chk("rv_delay", rv_cyc - req_cyc, exp_cyc - req_cyc);
        end
        repeat (hold) tick();
        if (late_rsp) begin
            rsp_valid = 1'b1; rsp_hit = 1'b1; rsp_num_hit = 4'd9;
            tick();
            rsp_valid = 1'b0;
            repeat (2) tick();
        end
        key_score_L = 1'b1;
        repeat (DEB + 6) tick();
        chk("req_count", req_cnt - r0, 1);
        chk("rv_count", rv_cnt - v0, 1);
    endtask

    task automatic reset_in_wait();
        int   r0, v0;
        bit   ok;
        req_t rq;
        x_in = 4'd1; y_in = 4'd2; big_in = 1'b1;
        rq.x = 4'd1; rq.y = 4'd2; rq.big = 1'b1;
        exp_req.push_back(rq);
        r0 = req_cnt; v0 = rv_cnt;
        key_score_L = 1'b0;
        wait_req(r0, ok);
        if (!ok) chk("req_seen_rw", 0, 1);
        repeat (3) tick();
        key_score_L = 1'b1;
        #2 reset_L = 1'b0;
        #1;
        m_big = BIGB; m_shots = 0; m_hits = 0;
        chk("rst_big_left", big_left, m_big);
        chk("rst_shots", shots_fired, m_shots);
        chk("rst_hits", hits_total, m_hits);
        chk("rst_res_wrong", res_wrong, 0);
        chk("rst_score_x", score_x, 0);
        rsp_valid = 1'b1;
        tick(); tick();
        reset_L = 1'b1;
        tick();
        rsp_valid = 1'b1; rsp_num_hit = 4'd5;
        tick();
        rsp_valid = 1'b0;
        repeat (20) tick();
        chk("rv_after_reset", rv_cnt - v0, 0);
        chk("big_left_after_reset", big_left, m_big);
        chk("shots_after_reset", shots_fired, m_shots);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        bit bounce [9];
        ships[0] = SHIP_NONE; ships[1] = PATROL; ships[2] = SUB;
        ships[3] = CRUISER;   ships[4] = BATTLESHIP; ships[5] = CARRIER;

        // Reset state while reset_L is held low
        repeat (3) tick();
        chk("init_big_left", big_left, BIGB);
        chk("init_score_req", score_req, 0);
        chk("init_result_valid", result_valid, 0);
        chk("init_shots", shots_fired, 0);
        chk("init_hits", hits_total, 0);
        chk("init_res_timeout", res_timeout, 0);
        chk("init_res_ship", res_ship, 0);
        reset_L = 1'b1;
        repeat (3) tick();

        // Bouncy key, never low long enough to count
        bounce = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        r0 = req_cnt;
        for (int i = 0; i < 9; i++) begin
            key_score_L = bounce[i];
            tick();
        end
        key_score_L = 1'b1;
        repeat (10) tick();
        chk("bounce_no_req", req_cnt - r0, 0);

        // Good big shot at (5,3), key held another 100 cycles
        do_shot(0, 4'd5, 4'd3, 1'b1, 0, 1'b1, 1'b0, 1'b0, CARRIER, 4'd3, 100, 1'b0);
        // Rejected big shot
        do_shot(1, 4'd7, 4'd9, 1'b1, 2, 1'b1, 1'b1, 1'b0, BATTLESHIP, 4'd4, 0, 1'b0);
        // Scorer silent, then a stray response while releasing
        do_shot(2, 4'd2, 4'd2, 1'b0, 0, 1'b0, 1'b0, 1'b1, SHIP_NONE, 4'd0, 3, 1'b1);
        // Reset while waiting for the scorer
        reset_in_wait();

        // Randomized shots; long enough to saturate both tallies and drain the inventory
        for (int n = 0; n < 330; n++) begin
            int   r, mode;
            r    = int'($urandom_range(0, 9));
            mode = (r < 8) ? 0 : ((r == 8) ? 1 : 2);
            do_shot(mode, 4'($urandom), 4'($urandom), 1'($urandom),
                    int'($urandom_range(0, 15)),
                    1'($urandom), 1'($urandom), 1'($urandom),
                    ships[$urandom_range(0, 5)], 4'($urandom_range(0, 9)),
                    int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shot_controller.md
# shot_controller

Request side of the shot-scoring interface. Conditions the raw score key into a single clean press event and latches the shot coordinates and bomb type. Issues a one-cycle score request to the combinational scorer, then waits for its response and captures the results. Owns the big-bomb inventory and the running shot and hit tallies that feed the display logic.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500_000: cycles the synchronized key must hold steady before its level is accepted (10 ms at 50 MHz).
- BIG_BOMBS, 2: big-bomb inventory loaded at reset; legal range 0..2.
- TIMEOUT_CYCLES, 16: maximum WAIT cycles before the request is abandoned.

Ports:
- clock, in, 1: the single clock.
- reset_L, in, 1: reset, asynchronous and active-low.
- key_score_L, in, 1: raw push-button, active-low, asynchronous to clock.
- x_in / y_in, in, 4 each: shot coordinates.
- big_in, in, 1: big bomb requested.
- score_req, out, 1: one-cycle request pulse.
- score_x / score_y, out, 4 each: latched coordinates, stable from REQ until the next press.
- score_big, out, 1: latched big flag.
- big_left, out, 2: remaining big bombs, also sent to the scorer.
- rsp_valid, in, 1: scorer response strobe.
- rsp_wrong, in, 1: scorer rejected the shot.
- rsp_hit / rsp_near / rsp_miss, in, 1 each: scorer result flags.
- rsp_ship, in, 5: one-hot biggest ship hit.
- rsp_num_hit, in, 4: squares hit by this shot, 0..9.
- res_hit / res_near / res_miss, out, 1 each: latched result flags.
- res_ship, out, 5: latched biggest ship.
- res_num_hit, out, 4: latched hit count.
- res_wrong, out, 1: latched reject flag.
- res_timeout, out, 1: last request timed out.
- result_valid, out, 1: one-cycle pulse when the res_* outputs update.
- shots_fired, out, 8: accepted shots, saturating.
- hits_total, out, 8: cumulative squares hit, saturating.

## Operation
- Key path: 2-flop synchronizer, then a debouncer. The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles. A press event is the debounced 1→0 edge.
- FSM states and transitions:
  - IDLE: on a press event, latch x_in, y_in and big_in, then go to REQ.
  - REQ: score_req=1 for exactly one cycle, then go to WAIT and clear the timeout counter.
  - WAIT: on rsp_valid, go to UPDATE. Otherwise, once the counter reaches TIMEOUT_CYCLES, go to UPDATE with the timeout flag set.
  - UPDATE: one cycle. Load all res_* outputs and pulse result_valid, then go to RELEASE.
  - RELEASE: wait for the debounced key to return high, then go to IDLE. Holding the key down never produces a second shot.
- UPDATE rules:
  - Timeout: res_timeout=1, res_wrong=1, other res_* cleared, counters and inventory unchanged.
  - rsp_wrong=1: res_wrong=1, other res_* cleared, counters and inventory unchanged.
  - Otherwise: copy the rsp_* values into res_*. shots_fired +1 and hits_total += rsp_num_hit, both saturating at 255. If score_big=1 and big_left>0, big_left −1.
- big_left never wraps and never exceeds BIG_BOMBS. The controller issues a big request even when big_left=0; the scorer is responsible for rejecting it.
- rsp_valid is ignored in every state except WAIT.
- Press events are ignored outside IDLE.
- Changes on x_in, y_in or big_in after the latch have no effect on the shot in flight.

## Timing
- Reset values: FSM in IDLE; big_left=BIG_BOMBS; every other output 0, including all counters and all res_* outputs.
- Reset asserted in any state returns the FSM to IDLE asynchronously. No result_valid is produced for the interrupted shot. A late rsp_valid after reset is ignored.
- Press latency: raw falling edge → 2 sync cycles → DEBOUNCE_CYCLES → press event. The latch happens in that same cycle; score_req is high the next cycle.
- rsp_valid may arrive as early as the cycle after score_req. res_* and result_valid update the cycle after rsp_valid is sampled.
- Timeout: no rsp_valid within TIMEOUT_CYCLES cycles after REQ → UPDATE.

## Structure
- battleship_pkg holds:
  - the shot FSM state enum;
  - the one-hot ship constants: SHIP_NONE=00000, PATROL=00001, SUB=00010, CRUISER=00100, BATTLESHIP=01000, CARRIER=10000;
  - the coordinate width of 4;
  - the counter width of 8.
- One sub-module: key_debouncer, parameter DEBOUNCE_CYCLES, containing the synchronizer and hold counter. It outputs the debounced level and the press pulse.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=16.
- Reset: drop reset_L mid-cycle → big_left=2, every other output 0 immediately.
- Debounce and latch:
  - key low for 3 cycles with bouncing → no score_req;
  - key held low for 10 cycles with x_in=5, y_in=3 → exactly one score_req, score_x=5, score_y=3;
  - key held low for a further 100 cycles → no second request.
- Good big shot: big_in=1; rsp_valid one cycle after score_req with rsp_num_hit=3, rsp_ship=10000 → result_valid once, res_ship=10000, big_left=1, shots_fired=1, hits_total=3.
- Rejected shot: rsp_wrong=1 on a big shot → res_wrong=1, big_left, shots_fired and hits_total all unchanged.
- Timeout: no rsp_valid → result_valid exactly 16 cycles after WAIT is entered with res_timeout=1; an rsp_valid pulse in RELEASE is ignored.
- Reset in WAIT: assert reset_L low during WAIT, then pulse rsp_valid → no result_valid, FSM in IDLE, big_left=2.
